// File: rtl/bus_stream_port_if.sv
// Processor address/strobe lines plus the TX/RX stream handshakes of bus_stream_port.
// DataBus is bidirectional and stays a plain port on the block.
interface bus_stream_port_if;
  logic [11:0] AddressBus;
  logic        Mem_Write;
  logic [15:0] TxData;
  logic        TxValid;
  logic        TxReady;
  logic [15:0] RxData;
  logic        RxValid;
  logic        RxReady;

  modport slave (
    input  AddressBus, Mem_Write, TxReady, RxData, RxValid,
    output TxData, TxValid, RxReady
  );

  modport master (
    output AddressBus, Mem_Write, TxReady, RxData, RxValid,
    input  TxData, TxValid, RxReady
  );
endinterface

// File: rtl/bus_stream_port.sv
// Memory-mapped 4-word window bridging processor load/store cycles to a
// FIFO-buffered TX stream and a single-register RX stream.
module bus_stream_port #(
  parameter logic [11:0] BASE  = 12'hFF0,
  parameter int          DEPTH = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  inout  wire [15:0]      DataBus,
  bus_stream_port_if.slave bus
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] FULL_CNT = 4'(DEPTH);

  typedef enum logic [1:0] {
    OFF_TXDATA = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_RXDATA = 2'd2,
    OFF_RSVD   = 2'd3
  } offset_e;

  logic        sel, rd_en, wr_en;
  offset_e     offset;
  logic [15:0] rdata;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0]    count_q, count_d;
  logic [15:0]   tx_data_q, tx_data_d;
  logic          ovf_q, ovf_d;
  logic          rx_valid_q, rx_valid_d;
  logic [15:0]   rx_hold_q, rx_hold_d;

  logic tx_empty, tx_full, push_req, push, pop, clr_ovf, clr_rx, capture;

  assign sel    = (bus.AddressBus[11:2] == BASE[11:2]);
  assign offset = offset_e'(bus.AddressBus[1:0]);
  assign wr_en  = sel && bus.Mem_Write;
  assign rd_en  = sel && !bus.Mem_Write;

  assign tx_empty = (count_q == 4'd0);
  assign tx_full  = (count_q == FULL_CNT);
  assign push_req = wr_en && (offset == OFF_TXDATA);
  assign pop      = !tx_empty && bus.TxReady;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push     = push_req && (!tx_full || pop);
  assign clr_ovf  = wr_en && (offset == OFF_STATUS) && DataBus[7];
  assign clr_rx   = wr_en && (offset == OFF_STATUS) && DataBus[6];
  assign capture  = bus.RxValid && !rx_valid_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    tx_data_d  = tx_data_q;
    ovf_d      = ovf_q;
    rx_valid_d = rx_valid_q;
    rx_hold_d  = rx_hold_q;

    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (push && !pop)      count_d = count_q + 4'd1;
    else if (pop && !push) count_d = count_q - 4'd1;

    // Registered head word: moves only on a pop, or on a push into an empty FIFO.
    if (pop) begin
      if (count_q > 4'd1) tx_data_d = mem_q[rd_ptr_d];
      else if (push)      tx_data_d = DataBus;
    end else if (push && tx_empty) begin
      tx_data_d = DataBus;
    end

    if (clr_ovf)         ovf_d = 1'b0;
    if (push_req && !push) ovf_d = 1'b1;

    if (clr_rx) rx_valid_d = 1'b0;
    if (capture) begin
      rx_valid_d = 1'b1;
      rx_hold_d  = bus.RxData;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (Reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_hold_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      rx_hold_q  <= rx_hold_d;
    end
  end

  // NOTE: storage array has no reset; only words below count are ever observed.
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= DataBus;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      OFF_STATUS: rdata = {8'h00, ovf_q, rx_valid_q, tx_full, tx_empty, count_q};
      OFF_RXDATA: rdata = rx_hold_q;
      default:    rdata = '0;
    endcase
  end

  assign DataBus     = rd_en ? rdata : 16'hzzzz;
  assign bus.TxData  = tx_data_q;
  assign bus.TxValid = !tx_empty;
  assign bus.RxReady = !rx_valid_q;

endmodule

// File: tb/tb_bus_stream_port.sv
// Scoreboard bench for bus_stream_port: TX words are queued as they are written
// and compared as the stream consumer takes them; register reads checked inline.
module tb_bus_stream_port;

  localparam int          DEPTH = 8;
  localparam logic [11:0] BASE  = 12'hFF0;
  localparam logic [11:0] A_TX  = 12'hFF0;
  localparam logic [11:0] A_ST  = 12'hFF1;
  localparam logic [11:0] A_RX  = 12'hFF2;
  localparam logic [11:0] A_R3  = 12'hFF3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire  [15:0] data_bus;
  logic        tb_drv   = 1'b0;
  logic [15:0] tb_wdata = '0;
  assign data_bus = tb_drv ? tb_wdata : 16'hzzzz;

  bus_stream_port_if ifc ();

  bus_stream_port #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .Clock   (clk),
    .Reset   (rst),
    .DataBus (data_bus),
    .bus     (ifc)
  );

  int          n_vec  = 0;
  int          n_err  = 0;
  int          n_pops = 0;
  logic [15:0] tx_exp [$];
  logic [15:0] last_pop = '0;
  logic        pend_push = 1'b0;
  logic [15:0] pend_data = '0;
  logic        mon_en = 1'b0;
  logic [15:0] rd;
  int          m_sz;
  bit          m_pop;

  // Stream side: inputs are stable from posedge+2 through the next posedge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      m_sz  = tx_exp.size();
      m_pop = (m_sz != 0) && ifc.TxReady;
      n_vec++;
      if (ifc.TxValid !== (m_sz != 0)) begin
        n_err++;
        $display("FAIL txvalid: got %b expected %b", ifc.TxValid, (m_sz != 0));
      end
      if (m_pop) begin
        n_vec++;
        if (ifc.TxData !== tx_exp[0]) begin
          n_err++;
          $display("FAIL txdata: got %h expected %h", ifc.TxData, tx_exp[0]);
        end
        last_pop = tx_exp.pop_front();
        n_pops++;
      end
      if (pend_push && (m_sz < DEPTH || m_pop)) tx_exp.push_back(pend_data);
    end
  end

  task automatic bus_write(input logic [11:0] a, input logic [15:0] d);
    @(posedge clk); #2;
    ifc.AddressBus = a;
    ifc.Mem_Write  = 1'b1;
    tb_drv         = 1'b1;
    tb_wdata       = d;
    pend_push      = (a[11:2] == BASE[11:2]) && (a[1:0] == 2'd0);
    pend_data      = d;
  endtask

  task automatic bus_idle();
    @(posedge clk); #2;
    ifc.Mem_Write  = 1'b0;
    ifc.AddressBus = 12'h000;
    tb_drv         = 1'b0;
    pend_push      = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [15:0] d);
    ifc.AddressBus = a;
    ifc.Mem_Write  = 1'b0;
    #1;
    d = data_bus;
    ifc.AddressBus = 12'h000;
  endtask

  task automatic drain();
    ifc.TxReady = 1'b1;
    for (int i = 0; i < 4 * DEPTH && tx_exp.size() != 0; i++) @(posedge clk);
    #2;
    ifc.TxReady = 1'b0;
    n_vec++;
    if (tx_exp.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d words left expected 0", tx_exp.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0010) begin n_err++; $display("FAIL reset_status: got %h expected 0010", rd); end
    n_vec++;
    if (ifc.RxReady !== 1'b1) begin n_err++; $display("FAIL reset_rxready: got %b expected 1", ifc.RxReady); end
    n_vec++;
    if (ifc.TxData !== 16'h0000) begin n_err++; $display("FAIL reset_txdata: got %h expected 0000", ifc.TxData); end
    // The bench holds 0000 on the bus; any DUT drive would corrupt it.
    tb_drv   = 1'b1;
    tb_wdata = 16'h0000;
    bus_read(12'h000, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL bus_float_000: got %h expected 0000", rd); end
    bus_read(12'hFF5, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL bus_float_ff5: got %h expected 0000", rd); end
    ifc.AddressBus = A_ST;
    ifc.Mem_Write  = 1'b1;
    #1;
    rd = data_bus;
    ifc.Mem_Write  = 1'b0;
    ifc.AddressBus = 12'h000;
    tb_drv         = 1'b0;
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL bus_float_write: got %h expected 0000", rd); end
  endtask

  task automatic test_overflow();
    int p0;
    ifc.TxReady = 1'b0;
    for (int i = 1; i <= 8; i++) bus_write(A_TX, 16'hA000 + 16'(i));
    bus_write(A_TX, 16'hDEAD);
    bus_idle();
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h00A8) begin n_err++; $display("FAIL ovf_status: got %h expected 00A8", rd); end
    bus_read(A_TX, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL txdata_read: got %h expected 0000", rd); end
    bus_read(A_R3, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL off3_read: got %h expected 0000", rd); end
    p0 = n_pops;
    @(posedge clk); #2;
    drain();
    n_vec++;
    if (n_pops - p0 != 8) begin n_err++; $display("FAIL ovf_popcount: got %0d expected 8", n_pops - p0); end
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0090) begin n_err++; $display("FAIL ovf_drained: got %h expected 0090", rd); end
  endtask

  task automatic test_ovf_clear();
    bus_write(A_ST, 16'h0080);
    bus_idle();
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0010) begin n_err++; $display("FAIL ovf_clear: got %h expected 0010", rd); end
  endtask

  task automatic test_full_pushpop();
    ifc.TxReady = 1'b0;
    for (int i = 1; i <= 8; i++) bus_write(A_TX, 16'hC000 + 16'(i));
    bus_idle();
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0028) begin n_err++; $display("FAIL full_status: got %h expected 0028", rd); end
    bus_write(A_TX, 16'hBEEF);
    ifc.TxReady = 1'b1;
    bus_idle();
    ifc.TxReady = 1'b0;
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0028) begin n_err++; $display("FAIL full_pushpop: got %h expected 0028", rd); end
    drain();
    n_vec++;
    if (last_pop !== 16'hBEEF) begin n_err++; $display("FAIL beef_last: got %h expected BEEF", last_pop); end
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0010) begin n_err++; $display("FAIL pushpop_end: got %h expected 0010", rd); end
  endtask

  task automatic test_rx();
    @(posedge clk); #2;
    ifc.RxData  = 16'h1234;
    ifc.RxValid = 1'b1;
    @(posedge clk); #2;
    n_vec++;
    if (ifc.RxReady !== 1'b0) begin n_err++; $display("FAIL rx_ready_low: got %b expected 0", ifc.RxReady); end
    bus_read(A_RX, rd);
    n_vec++;
    if (rd !== 16'h1234) begin n_err++; $display("FAIL rx_data: got %h expected 1234", rd); end
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0050) begin n_err++; $display("FAIL rx_status: got %h expected 0050", rd); end
    ifc.RxData = 16'h5678;
    @(posedge clk); #2;
    bus_read(A_RX, rd);
    n_vec++;
    if (rd !== 16'h1234) begin n_err++; $display("FAIL rx_hold: got %h expected 1234", rd); end
    bus_write(A_ST, 16'h0040);
    bus_idle();
    n_vec++;
    if (ifc.RxReady !== 1'b1) begin n_err++; $display("FAIL rx_release: got %b expected 1", ifc.RxReady); end
    @(posedge clk); #2;
    n_vec++;
    if (ifc.RxReady !== 1'b0) begin n_err++; $display("FAIL rx_recapture: got %b expected 0", ifc.RxReady); end
    bus_read(A_RX, rd);
    n_vec++;
    if (rd !== 16'h5678) begin n_err++; $display("FAIL rx_data2: got %h expected 5678", rd); end
    ifc.RxValid = 1'b0;
    bus_write(A_ST, 16'h0040);
    bus_idle();
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0010) begin n_err++; $display("FAIL rx_cleared: got %h expected 0010", rd); end
  endtask

  task automatic test_reset_mid();
    ifc.TxReady = 1'b0;
    ifc.RxData  = 16'hE001;
    ifc.RxValid = 1'b1;
    for (int i = 1; i <= 3; i++) bus_write(A_TX, 16'hD000 + 16'(i));
    bus_idle();
    ifc.RxValid = 1'b0;
    @(posedge clk); #4;
    rst = 1'b1;
    tx_exp.delete();
    #1;
    n_vec++;
    if (ifc.TxValid !== 1'b0) begin n_err++; $display("FAIL midrst_txvalid: got %b expected 0", ifc.TxValid); end
    n_vec++;
    if (ifc.RxReady !== 1'b1) begin n_err++; $display("FAIL midrst_rxready: got %b expected 1", ifc.RxReady); end
    n_vec++;
    if (ifc.TxData !== 16'h0000) begin n_err++; $display("FAIL midrst_txdata: got %h expected 0000", ifc.TxData); end
    @(posedge clk); #2;
    rst = 1'b0;
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0010) begin n_err++; $display("FAIL midrst_status: got %h expected 0010", rd); end
    bus_read(A_RX, rd);
    n_vec++;
    if (rd !== 16'h0000) begin n_err++; $display("FAIL midrst_rxdata: got %h expected 0000", rd); end
  endtask

  task automatic test_back_to_back();
    int p0;
    ifc.TxReady = 1'b0;
    for (int i = 1; i <= 4; i++) bus_write(A_TX, 16'hF000 + 16'(i));
    bus_idle();
    drain();
    // Streaming with the consumer always ready: one push and one pop per cycle.
    ifc.TxReady = 1'b1;
    for (int i = 5; i <= 10; i++) bus_write(A_TX, 16'hF000 + 16'(i));
    bus_idle();
    drain();
    ifc.TxReady = 1'b0;
    for (int i = 1; i <= 8; i++) bus_write(A_TX, 16'h9000 + 16'(i));
    bus_idle();
    bus_read(A_ST, rd);
    n_vec++;
    if (rd !== 16'h0028) begin n_err++; $display("FAIL wrap_full: got %h expected 0028", rd); end
    p0 = n_pops;
    drain();
    n_vec++;
    if (n_pops - p0 != 8) begin n_err++; $display("FAIL wrap_popcount: got %0d expected 8", n_pops - p0); end
    n_vec++;
    if (last_pop !== 16'h9008) begin n_err++; $display("FAIL wrap_last: got %h expected 9008", last_pop); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.AddressBus = 12'h000;
    ifc.Mem_Write  = 1'b0;
    ifc.TxReady    = 1'b0;
    ifc.RxData     = 16'h0000;
    ifc.RxValid    = 1'b0;
    test_reset();
    test_overflow();
    test_ovf_clear();
    test_full_pushpop();
    test_rx();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
